term_tx_arbiter: RTL and testbench

//  Shares the single terminal UART transmit byte channel (GPIO16-muxed UART,
//  115200 bps) between NUM_REQ byte-stream requesters (firmware console,

---
 rtl/term_tx_arbiter.sv | 119 +++++++++++
 tb/tb_term_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_tx_arbiter.sv
// Line-granular round-robin arbiter sharing the terminal UART TX byte channel.
// Bytes pass combinationally from the owner; grants release on EOL, burst limit or idle timeout.
module term_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter logic [7:0]  EOL_BYTE     = 8'h0A,
   parameter int unsigned MAX_BURST    = 128,
   parameter int unsigned IDLE_TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [2:0]           grant_id,
   output logic                 busy
);

   localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e           state_q;
   logic [2:0]       grant_q;
   logic [2:0]       rr_last_q;
   logic [7:0]       byte_cnt_q;
   logic [IdleW-1:0] idle_cnt_q;

   // Requester vectors padded to the 8-requester maximum so a 3-bit owner index is exact.
   logic [7:0]  valid8;
   logic [7:0]  last8;
   logic [7:0]  ready8;
   logic [63:0] data64;
   logic        owner_valid;
   logic        owner_last;
   logic [7:0]  owner_data;
   logic        beat;
   logic        burst_hit;
   logic        idle_hit;
   logic        release_grant;
   logic [2:0]  pick;
   logic        pick_found;
   int          cand;

   assign valid8      = 8'(req_valid);
   assign last8       = 8'(req_last);
   assign data64      = 64'(req_data);
   assign owner_valid = valid8[grant_q];
   assign owner_last  = last8[grant_q];
   assign owner_data  = data64[{grant_q, 3'b000} +: 8];

   assign busy      = (state_q == StXfer);
   assign grant_id  = grant_q;
   assign tx_valid  = busy & owner_valid;
   assign tx_data   = owner_data;
   assign ready8    = busy ? (8'(tx_ready) << grant_q) : 8'd0;
   assign req_ready = ready8[NUM_REQ-1:0];

   assign beat      = tx_valid & tx_ready;
   assign burst_hit = (byte_cnt_q + 8'd1) == 8'(MAX_BURST);
   // A stalled FIFO with the owner still valid is not idleness.
   assign idle_hit  = !owner_valid && ((idle_cnt_q + IdleW'(1)) == IdleW'(IDLE_TIMEOUT));

   assign release_grant = busy &
                          ((beat & (owner_last | (owner_data == EOL_BYTE) | burst_hit)) | idle_hit);

   // Round-robin search starting just after the previous owner.
   always_comb begin
      pick       = rr_last_q;
      pick_found = 1'b0;
      cand       = 0;
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
         cand = int'(rr_last_q) + i;
         if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
         if (!pick_found && valid8[3'(cand)]) begin
            pick_found = 1'b1;
            pick       = 3'(cand);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= 3'd0;
         rr_last_q  <= 3'(NUM_REQ - 1);
         byte_cnt_q <= 8'd0;
         idle_cnt_q <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (pick_found) begin
                  state_q    <= StXfer;
                  grant_q    <= pick;
                  byte_cnt_q <= 8'd0;
                  idle_cnt_q <= '0;
               end
            end
            StXfer: begin
               if (release_grant) begin
                  state_q    <= StIdle;
                  rr_last_q  <= grant_q;
                  byte_cnt_q <= 8'd0;
                  idle_cnt_q <= '0;
               end else begin
                  if (beat) byte_cnt_q <= byte_cnt_q + 8'd1;
                  if (owner_valid) idle_cnt_q <= '0;
                  else             idle_cnt_q <= idle_cnt_q + IdleW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_term_tx_arbiter.sv
// Directed bench for term_tx_arbiter: byte-queue requesters, a beat log, hand-computed expectations.
module tb_term_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [2:0]  grant_id;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-requester pending bytes: bit 8 is the req_last flag.
   logic [8:0]  rq [4][$];
   logic [10:0] beat_log [$];
   logic [10:0] exp_log [$];

   term_tx_arbiter #(
      .NUM_REQ      (4),
      .EOL_BYTE     (8'h0A),
      .MAX_BURST    (4),
      .IDLE_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .grant_id  (grant_id),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < 4; i++) begin
         if (rq[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = rq[i][0][7:0];
            req_last[i]        = rq[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   // Called at the negedge: record handshakes, then move to just after the next posedge.
   task automatic adv();
      for (int i = 0; i < 4; i++)
         if (req_valid[i] && req_ready[i]) void'(rq[i].pop_front());
      if (tx_valid && tx_ready) beat_log.push_back({grant_id, tx_data});
      @(posedge clk);
      #1;
      apply();
   endtask

   task automatic reset_dut();
      rst      = 1'b1;
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) rq[i].delete();
      apply();
      neg(); adv();
      neg(); adv();
      rst = 1'b0;
      beat_log.delete();
      exp_log.delete();
   endtask

   task automatic expect_beat(input logic [2:0] g, input logic [7:0] b);
      exp_log.push_back({g, b});
   endtask

   task automatic drain(input string tag);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 300 && !done; c++) begin
         neg();
         done = !busy && rq[0].size() == 0 && rq[1].size() == 0 &&
                rq[2].size() == 0 && rq[3].size() == 0;
         adv();
      end
      check({tag, "_drain_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic compare_log(input string tag);
      check({tag, "_len"}, 32'(beat_log.size()), 32'(exp_log.size()));
      for (int i = 0; i < exp_log.size() && i < beat_log.size(); i++)
         check($sformatf("%s_beat%0d", tag, i), 32'(beat_log[i]), 32'(exp_log[i]));
      beat_log.delete();
      exp_log.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      logic       done;
      rst = 1'b1; tx_ready = 1'b1;
      req_valid = '0; req_data = '0; req_last = '0;

      // Reset state
      reset_dut();
      neg();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_txv", 32'(tx_valid), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      adv();

      // 1: "AB\r\n" from req0, one IDLE cycle then four consecutive bytes
      rq[0].push_back(9'h041); rq[0].push_back(9'h042);
      rq[0].push_back(9'h00D); rq[0].push_back(9'h00A);
      apply();
      neg();
      check("t1_arb_txv", 32'(tx_valid), 32'd0);
      check("t1_arb_busy", 32'(busy), 32'd0);
      adv();
      begin
         logic [7:0] t1 [4];
         t1 = '{8'h41, 8'h42, 8'h0D, 8'h0A};
         for (int k = 0; k < 4; k++) begin
            neg();
            check($sformatf("t1_txv%0d", k), 32'(tx_valid), 32'd1);
            check($sformatf("t1_data%0d", k), 32'(tx_data), 32'(t1[k]));
            check($sformatf("t1_ready%0d", k), 32'(req_ready), 32'h1);
            adv();
         end
      end
      neg();
      check("t1_rel_busy", 32'(busy), 32'd0);
      check("t1_rel_txv", 32'(tx_valid), 32'd0);
      adv();
      beat_log.delete();

      // 2: three simultaneous 3-byte lines, served 0, 1, 2 without interleave
      reset_dut();
      rq[0].push_back(9'h061); rq[0].push_back(9'h062); rq[0].push_back(9'h00A);
      rq[1].push_back(9'h063); rq[1].push_back(9'h064); rq[1].push_back(9'h165);
      rq[2].push_back(9'h066); rq[2].push_back(9'h067); rq[2].push_back(9'h00A);
      apply();
      drain("t2");
      expect_beat(3'd0, 8'h61); expect_beat(3'd0, 8'h62); expect_beat(3'd0, 8'h0A);
      expect_beat(3'd1, 8'h63); expect_beat(3'd1, 8'h64); expect_beat(3'd1, 8'h65);
      expect_beat(3'd2, 8'h66); expect_beat(3'd2, 8'h67); expect_beat(3'd2, 8'h0A);
      compare_log("t2");

      // 3: req1 line with tx_ready toggling; ready mirrors tx_ready, data held while stalled
      reset_dut();
      rq[1].push_back(9'h078); rq[1].push_back(9'h079); rq[1].push_back(9'h17A);
      apply();
      prev_stall = 1'b0;
      prev_data  = 8'h00;
      done       = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         neg();
         if (busy) check("t3_ready", 32'(req_ready), 32'({tx_ready, 1'b0}));
         if (prev_stall) check("t3_hold", 32'(tx_data), 32'(prev_data));
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         done = !busy && rq[1].size() == 0;
         adv();
         tx_ready = ~tx_ready;
      end
      tx_ready = 1'b1;
      check("t3_done_busy", 32'(busy), 32'd0);
      expect_beat(3'd1, 8'h78); expect_beat(3'd1, 8'h79); expect_beat(3'd1, 8'h7A);
      compare_log("t3");

      // 4: burst limit 4 forces req0 to yield to req2 mid-stream
      reset_dut();
      for (int k = 0; k < 6; k++) rq[0].push_back(9'(8'h10 + k));
      rq[2].push_back(9'h020); rq[2].push_back(9'h021); rq[2].push_back(9'h00A);
      apply();
      drain("t4");
      expect_beat(3'd0, 8'h10); expect_beat(3'd0, 8'h11);
      expect_beat(3'd0, 8'h12); expect_beat(3'd0, 8'h13);
      expect_beat(3'd2, 8'h20); expect_beat(3'd2, 8'h21); expect_beat(3'd2, 8'h0A);
      expect_beat(3'd0, 8'h14); expect_beat(3'd0, 8'h15);
      compare_log("t4");

      // 5: req3 goes quiet after two bytes; released after 16 idle cycles, req0 next
      reset_dut();
      rq[3].push_back(9'h030); rq[3].push_back(9'h031);
      apply();
      neg(); adv();
      rq[0].push_back(9'h040); rq[0].push_back(9'h00A);
      apply();
      neg();
      check("t5_gid", 32'(grant_id), 32'd3);
      check("t5_b0", 32'(tx_data), 32'h30);
      adv();
      neg(); adv();
      for (int k = 1; k <= 16; k++) begin
         neg();
         check($sformatf("t5_idle%0d_busy", k), 32'(busy), 32'd1);
         adv();
      end
      neg();
      check("t5_rel_busy", 32'(busy), 32'd0);
      adv();
      neg();
      check("t5_next_gid", 32'(grant_id), 32'd0);
      check("t5_next_data", 32'(tx_data), 32'h40);
      adv();
      drain("t5");
      expect_beat(3'd3, 8'h30); expect_beat(3'd3, 8'h31);
      expect_beat(3'd0, 8'h40); expect_beat(3'd0, 8'h0A);
      compare_log("t5");

      // 6: reset mid-line of req2 abandons the grant; req0 wins the next arbitration
      reset_dut();
      rq[2].push_back(9'h050); rq[2].push_back(9'h051);
      rq[2].push_back(9'h052); rq[2].push_back(9'h10A);
      apply();
      neg(); adv();
      neg(); check("t6_b0", 32'(tx_data), 32'h50); adv();
      neg(); check("t6_b1", 32'(tx_data), 32'h51); adv();
      rst = 1'b1;
      tx_ready = 1'b0;
      neg(); adv();
      rst = 1'b0;
      tx_ready = 1'b1;
      rq[0].push_back(9'h060); rq[0].push_back(9'h00A);
      apply();
      neg();
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_txv", 32'(tx_valid), 32'd0);
      check("t6_ready", 32'(req_ready), 32'd0);
      adv();
      neg();
      check("t6_next_busy", 32'(busy), 32'd1);
      check("t6_next_gid", 32'(grant_id), 32'd0);
      adv();
      drain("t6");
      expect_beat(3'd2, 8'h50); expect_beat(3'd2, 8'h51);
      expect_beat(3'd0, 8'h60); expect_beat(3'd0, 8'h0A);
      expect_beat(3'd2, 8'h52); expect_beat(3'd2, 8'h0A);
      compare_log("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
